// File: rtl/frac_logic_cfg_param.sv
// Fracturable LUT block: one LUT_SIZE-input LUT or two shared-input (LUT_SIZE-1)-input LUTs,
// configured through a serial chain with load tracking, optional output registers and output gating.
module frac_logic_cfg_param #(
    parameter  int LUT_SIZE = 4,
    localparam int CFG_BITS = 2**LUT_SIZE + 3
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                ccff_en,
    input  logic                ccff_head,
    output logic                ccff_tail,
    input  logic [LUT_SIZE-1:0] frac_logic_in,
    output logic [1:0]          frac_logic_out,
    output logic                cfg_done,
    output logic                cfg_overflow
);

    localparam int MASK_BITS = 2**LUT_SIZE;
    localparam int CNT_W     = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0]  r_cfg;
    logic [CNT_W-1:0]     r_shiftCnt;
    logic                 r_overflow;
    logic [1:0]           r_outQ;

    logic [MASK_BITS-1:0] w_mask;
    logic                 w_sel0;
    logic [1:0]           w_reg;
    logic [LUT_SIZE-2:0]  w_addrA;
    logic                 w_lutA;
    logic                 w_lutB;
    logic                 w_lutK;
    logic [1:0]           w_comb;

    assign w_mask  = r_cfg[MASK_BITS-1:0];
    assign w_sel0  = r_cfg[MASK_BITS];
    assign w_reg   = r_cfg[MASK_BITS+2:MASK_BITS+1];
    assign w_addrA = frac_logic_in[LUT_SIZE-2:0];

    // The two half-LUTs share the low address bits; the top input picks between them.
    assign w_lutA = w_mask[{1'b0, w_addrA}];
    assign w_lutB = w_mask[{1'b1, w_addrA}];
    assign w_lutK = frac_logic_in[LUT_SIZE-1] ? w_lutB : w_lutA;
    assign w_comb = {w_lutB, (w_sel0 ? w_lutK : w_lutA)};

    assign ccff_tail    = r_cfg[CFG_BITS-1];
    assign cfg_done     = (r_shiftCnt == CNT_MAX);
    assign cfg_overflow = r_overflow;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_cfg      <= '0;
            r_shiftCnt <= '0;
            r_overflow <= 1'b0;
            r_outQ     <= '0;
        end else begin
            if (ccff_en) begin
                r_cfg <= {r_cfg[CFG_BITS-2:0], ccff_head};
                // Shifting continues past a full load so the chain stays transparent downstream.
                if (r_shiftCnt == CNT_MAX) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_shiftCnt <= r_shiftCnt + 1'b1;
                end
            end
            if (cfg_done && !ccff_en) begin
                r_outQ <= w_comb;
            end
        end
    end

    always_comb begin
        frac_logic_out = '0;
        if (cfg_done) begin
            frac_logic_out[0] = w_reg[0] ? r_outQ[0] : w_comb[0];
            frac_logic_out[1] = w_reg[1] ? r_outQ[1] : w_comb[1];
        end
    end

endmodule

// File: tb/tb_frac_logic_cfg_param.sv
// Directed bench for frac_logic_cfg_param at LUT_SIZE=4: table-driven combinational LUT
// vectors plus hand-written load, registered-output, overflow and mid-load reset sequences.
module tb_frac_logic_cfg_param;

    localparam int LUT_SIZE = 4;
    localparam int CFG_BITS = 19;

    logic                prog_clk = 1'b0;
    logic                pReset = 1'b0;
    logic                ccff_en = 1'b0;
    logic                ccff_head = 1'b0;
    logic                ccff_tail;
    logic [LUT_SIZE-1:0] frac_logic_in = '0;
    logic [1:0]          frac_logic_out;
    logic                cfg_done;
    logic                cfg_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CFG_BITS-1:0] cfgWord;
        logic [LUT_SIZE-1:0] inVec;
        logic [1:0]          expOut;
        string               name;
    } vec_t;

    vec_t vecs[16];

    frac_logic_cfg_param #(.LUT_SIZE(LUT_SIZE)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .ccff_en       (ccff_en),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .frac_logic_in (frac_logic_in),
        .frac_logic_out(frac_logic_out),
        .cfg_done      (cfg_done),
        .cfg_overflow  (cfg_overflow)
    );

    always #5 prog_clk = ~prog_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [CFG_BITS-1:0] actual,
                               input logic [CFG_BITS-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [LUT_SIZE-1:0] inVec);
        frac_logic_in = inVec;
        #1;
    endtask

    task automatic doReset();
        pReset = 1'b1;
        @(posedge prog_clk);
        #1;
        pReset = 1'b0;
    endtask

    task automatic shiftBit(input logic b);
        ccff_en   = 1'b1;
        ccff_head = b;
        @(posedge prog_clk);
        #1;
        ccff_en   = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge prog_clk);
        #1;
    endtask

    // Layout is {REG1, REG0, SEL0, M[15:0]}; sent MSB first so it lands in place after 19 shifts.
    task automatic loadWord(input logic [CFG_BITS-1:0] w);
        for (int i = CFG_BITS - 1; i >= 0; i--) begin
            shiftBit(w[i]);
        end
    endtask

    initial begin
        logic [CFG_BITS-1:0] loaded;
        logic [CFG_BITS-1:0] w;

        // XOR4 with SEL0=1: out0 = parity(in), out1 = ~parity(in[2:0])
        vecs[0]  = '{19'h16996, 4'b1011, 2'b11, "xor_1011"};
        vecs[1]  = '{19'h16996, 4'b0000, 2'b10, "xor_0000"};
        vecs[2]  = '{19'h16996, 4'b0111, 2'b01, "xor_0111"};
        vecs[3]  = '{19'h16996, 4'b1000, 2'b11, "xor_1000"};
        vecs[4]  = '{19'h16996, 4'b0101, 2'b10, "xor_0101"};
        vecs[5]  = '{19'h16996, 4'b1110, 2'b11, "xor_1110"};
        // Split mode SEL0=0: out0 = in0&in1, out1 = majority(in0..in2), in3 ignored
        vecs[6]  = '{19'h0E888, 4'b0011, 2'b11, "split_0011"};
        vecs[7]  = '{19'h0E888, 4'b0101, 2'b10, "split_0101"};
        vecs[8]  = '{19'h0E888, 4'b1011, 2'b11, "split_1011"};
        vecs[9]  = '{19'h0E888, 4'b0001, 2'b00, "split_0001"};
        vecs[10] = '{19'h0E888, 4'b1111, 2'b11, "split_1111"};
        vecs[11] = '{19'h0E888, 4'b0110, 2'b10, "split_0110"};
        vecs[12] = '{19'h0E888, 4'b1100, 2'b00, "split_1100"};
        // M=FF00, SEL0=1: out0 follows in3 only, out1 constant 1
        vecs[13] = '{19'h1FF00, 4'b1000, 2'b11, "top_1000"};
        vecs[14] = '{19'h1FF00, 4'b0111, 2'b10, "top_0111"};
        vecs[15] = '{19'h1FF00, 4'b1111, 2'b11, "top_1111"};

        $display("[TB] start");

        // Reset state
        applyStimulus(4'b1111);
        doReset();
        checkOutput("rst_done", 19'(cfg_done), 19'd0);
        checkOutput("rst_ovf", 19'(cfg_overflow), 19'd0);
        checkOutput("rst_out", 19'(frac_logic_out), 19'd0);
        checkOutput("rst_tail", 19'(ccff_tail), 19'd0);

        // Load count boundary, tail delay, mixed REG config, then overflow
        w = 19'h56996;
        for (int i = CFG_BITS - 1; i >= 1; i--) begin
            shiftBit(w[i]);
        end
        checkOutput("cnt18_done", 19'(cfg_done), 19'd0);
        checkOutput("cnt18_out", 19'(frac_logic_out), 19'd0);
        shiftBit(w[0]);
        checkOutput("cnt19_done", 19'(cfg_done), 19'd1);
        checkOutput("tail_b18", 19'(ccff_tail), 19'(w[18]));
        applyStimulus(4'b1011);
        checkOutput("mixreg_pre", 19'(frac_logic_out), 19'b01);
        idleCycle();
        checkOutput("mixreg_post", 19'(frac_logic_out), 19'b11);
        checkOutput("ovf_before", 19'(cfg_overflow), 19'd0);
        shiftBit(1'b0);
        checkOutput("ovf_set", 19'(cfg_overflow), 19'd1);
        checkOutput("tail_b17", 19'(ccff_tail), 19'(w[17]));
        shiftBit(1'b0);
        checkOutput("tail_b16", 19'(ccff_tail), 19'(w[16]));
        shiftBit(1'b0);
        checkOutput("tail_b15", 19'(ccff_tail), 19'(w[15]));
        idleCycle();
        checkOutput("ovf_sticky", 19'(cfg_overflow), 19'd1);
        checkOutput("done_after_ovf", 19'(cfg_done), 19'd1);
        doReset();
        checkOutput("ovf_clr", 19'(cfg_overflow), 19'd0);
        checkOutput("done_clr", 19'(cfg_done), 19'd0);
        checkOutput("out_clr", 19'(frac_logic_out), 19'd0);

        // Table of combinational vectors, reloading when the config changes
        loaded = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || vecs[i].cfgWord != loaded) begin
                doReset();
                loadWord(vecs[i].cfgWord);
                loaded = vecs[i].cfgWord;
            end
            applyStimulus(vecs[i].inVec);
            checkOutput(vecs[i].name, 19'(frac_logic_out), 19'(vecs[i].expOut));
        end

        // Both outputs registered: one-cycle latency, hold while shifting
        doReset();
        loadWord(19'h76996);
        applyStimulus(4'b0000);
        idleCycle();
        checkOutput("reg_settle", 19'(frac_logic_out), 19'b10);
        applyStimulus(4'b1011);
        checkOutput("reg_no_change", 19'(frac_logic_out), 19'b10);
        idleCycle();
        checkOutput("reg_one_cycle", 19'(frac_logic_out), 19'b11);
        applyStimulus(4'b0000);
        shiftBit(1'b0);
        checkOutput("reg_hold_en", 19'(frac_logic_out), 19'b11);
        checkOutput("reg_ovf", 19'(cfg_overflow), 19'd1);

        // Reset coincident with the 10th shift clears progress and the chain
        doReset();
        for (int i = 0; i < 9; i++) begin
            shiftBit(1'b1);
        end
        ccff_en   = 1'b1;
        ccff_head = 1'b1;
        pReset    = 1'b1;
        @(posedge prog_clk);
        #1;
        ccff_en = 1'b0;
        pReset  = 1'b0;
        checkOutput("midrst_done", 19'(cfg_done), 19'd0);
        w = 19'h16996;
        for (int i = CFG_BITS - 1; i >= 9; i--) begin
            shiftBit(w[i]);
            checkOutput("midrst_tail0", 19'(ccff_tail), 19'd0);
        end
        for (int i = 8; i >= 1; i--) begin
            shiftBit(w[i]);
        end
        checkOutput("midrst_cnt18", 19'(cfg_done), 19'd0);
        shiftBit(w[0]);
        checkOutput("midrst_cnt19", 19'(cfg_done), 19'd1);
        applyStimulus(4'b1011);
        checkOutput("midrst_func", 19'(frac_logic_out), 19'b11);
        checkOutput("midrst_ovf", 19'(cfg_overflow), 19'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frac_logic_cfg_param.md
Name: frac_logic_cfg_param

Overview:
- Parametrised fracturable LUT logic block for the next-generation CLB.
- Operates as one LUT_SIZE-input LUT or as two (LUT_SIZE-1)-input LUTs that share inputs.
- Adds three things: an enable-gated configuration shift chain with a bit counter and load-status flags, per-output optional registering, and output gating until configuration completes.
- Sits inside the fle between the input direct interconnect and the fle output routing, chained via ccff_head/ccff_tail.

Parameters:
- LUT_SIZE, 4, number of LUT inputs. Legal range 2..6.
- CFG_BITS, 2**LUT_SIZE+3, derived and not overridable. Total configuration bits; 19 at default.

Ports:
- prog_clk  input  1  the only clock; all state updates on the rising edge.
- pReset  input  1  synchronous, active-high reset.
- ccff_en  input  1  configuration shift enable.
- ccff_head  input  1  serial configuration data in.
- ccff_tail  output  1  serial configuration data out, to the next block in the chain.
- frac_logic_in  input  LUT_SIZE  LUT inputs; index 0 is the LSB of the LUT address.
- frac_logic_out  output  2  logic outputs.
- cfg_done  output  1  high once exactly CFG_BITS bits have been shifted since reset.
- cfg_overflow  output  1  sticky; set when a shift occurs after cfg_done.

Behaviour:
- Reset (pReset=1 at a clock edge): cfg[CFG_BITS-1:0]=0, shift_cnt=0, cfg_done=0, cfg_overflow=0, out_q[1:0]=0. Reset has priority over ccff_en.
- Shift: on an edge with ccff_en=1, cfg[0]<=ccff_head and cfg[i]<=cfg[i-1]. With ccff_en=0, cfg holds.
- ccff_tail = cfg[CFG_BITS-1], combinational from the register.
- Load order: the first bit shifted in ends in cfg[CFG_BITS-1], so data is loaded MSB first.
- Config layout:
  - cfg[2**LUT_SIZE-1:0] = mask M.
  - cfg[2**LUT_SIZE] = SEL0.
  - cfg[2**LUT_SIZE+1] = REG0.
  - cfg[2**LUT_SIZE+2] = REG1.
- Counter:
  - shift_cnt is $clog2(CFG_BITS+1) bits wide and increments on each shift.
  - It saturates at CFG_BITS.
  - cfg_done = (shift_cnt==CFG_BITS), registered-state derived, no extra latency.
- Overflow: a shift while shift_cnt==CFG_BITS sets cfg_overflow. It stays set until pReset. The shift itself still occurs, so the chain stays transparent for downstream blocks.
- LUT functions, with A = frac_logic_in[0:LUT_SIZE-2] as the address:
  - lutA = M[A].
  - lutB = M[2**(LUT_SIZE-1)+A].
  - lutK = frac_logic_in[LUT_SIZE-1] ? lutB : lutA, equivalent to M[full address].
- Output sources: comb0 = SEL0 ? lutK : lutA; comb1 = lutB.
- Output register: on each edge with cfg_done=1 and ccff_en=0, out_q[n]<=comb_n. Otherwise out_q holds (reset clears it).
- Output selection: frac_logic_out[n] = cfg_done ? (REGn ? out_q[n] : comb_n) : 0.
- Latency: 0 cycles when REGn=0; 1 cycle when REGn=1.
- Gating: outputs are 0 during loading and after reset. Once cfg_done, outputs follow the configuration even if an overflow shift later corrupts cfg; cfg_overflow flags that condition.
- Mid-load reset: all progress is lost and a full CFG_BITS shift is required again.
- ccff_en toggling: gaps in ccff_en are allowed; only enabled cycles count.

Test Plan (LUT_SIZE=4, CFG_BITS=19):
1. Reset, then 18 shifts -> cfg_done=0 and frac_logic_out=00. 19th shift -> cfg_done=1 on the next cycle. The bit stream then appears on ccff_tail delayed by 19 shift cycles.
2. Load M=16'h6996 (4-input XOR), SEL0=1, REG=00 -> frac_logic_out[0] = XOR of the inputs combinationally, e.g. in=4'b1011 gives 1. frac_logic_out[1] = M[8+A].
3. Load M=16'hE888, SEL0=0, REG=00 -> lower half 8'h88 (AND of in0,in1; in2 ignored), upper half 8'hE8 (majority of in0..in2). For in0=1,in1=1,in2=0 -> out0=1 and out1=1. For in0=1,in1=0,in2=1 -> out0=0 and out1=1.
4. Same as scenario 2 with REG0=1,REG1=1 -> outputs change exactly one prog_clk after an input change. With ccff_en=1 after done, out_q holds its value.
5. After cfg_done, one extra shift -> cfg_overflow=1 and it stays 1. pReset -> cfg_overflow=0, cfg_done=0, outputs 00.
6. pReset asserted on the same edge as ccff_en=1 at shift 10 -> shift_cnt=0 and cfg=0. A following full 19-bit load completes normally.
